// File: rtl/dmem_lsu.sv
// Load/store unit between the core and a single-port data memory.
// Aligns store lanes, extracts/extends load lanes, flags bad requests.
module dmem_lsu #(
  parameter int ADDR_BITS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;

  logic        accept;
  logic        bad;
  logic [3:0]  st_we;
  logic [31:0] st_data;
  logic [31:0] sh_data;
  logic [31:0] ld_ext;

  // Gated by reset so the core sees no acceptance while held in reset.
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    bad     = 1'b0;
    st_we   = 4'b0000;
    st_data = 32'd0;
    unique case (1'b1)
      req_size == 2'b00: begin
        st_we   = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      req_size == 2'b01: begin
        bad     = req_addr[0];
        st_we   = 4'b0011 << {req_addr[1], 1'b0};
        st_data = {2{req_wdata[15:0]}};
      end
      req_size == 2'b10: begin
        bad     = |req_addr[1:0];
        st_we   = 4'b1111;
        st_data = req_wdata;
      end
      default: bad = 1'b1;
    endcase
    if ((req_addr >> ADDR_BITS) != 32'd0)
      bad = 1'b1;
  end

  // Words are always aligned, so lane 0 makes the shift a no-op for them.
  always_comb begin
    sh_data = drdata >> {lane_q, 3'b000};
    ld_ext  = sh_data;
    unique case (1'b1)
      size_q == 2'b00:
        ld_ext = uns_q ? {24'd0, sh_data[7:0]}
                       : {{24{sh_data[7]}}, sh_data[7:0]};
      size_q == 2'b01:
        ld_ext = uns_q ? {16'd0, sh_data[15:0]}
                       : {{16{sh_data[15]}}, sh_data[15:0]};
      default: ld_ext = sh_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      daddr     <= 32'd0;
      dwdata    <= 32'd0;
      we        <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lane_q <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            we_q   <= req_we;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              state <= ISSUE;
              daddr <= {req_addr[31:2], 2'b00};
              if (req_we) begin
                we     <= st_we;
                dwdata <= st_data;
              end
            end
          end
        end
        ISSUE: begin
          we <= 4'b0000;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_ext;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-lane memory model.
// Each task drives one scenario and checks its own results.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata = 32'd0;

  logic [31:0] mem [0:31];
  int checks = 0;
  int errors = 0;

  dmem_lsu #(.ADDR_BITS(7)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we),
    .drdata(drdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    drdata <= mem[daddr[6:2]];
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[daddr[6:2]][8*i +: 8] <= dwdata[8*i +: 8];
  end

  // Presents one request, waits for acceptance, then records what
  // the memory port and response look like until rsp_valid (bounded).
  task automatic run_req(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        un,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output int          lat,
    output logic [3:0]  we_seen,
    output logic [31:0] a_seen,
    output logic [31:0] d_seen,
    output logic [31:0] rd,
    output logic        err
  );
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = w; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_seen = 4'b0000; a_seen = 32'd0;
    d_seen = 32'd0; rd = 32'hxxxxxxxx; err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (we != 4'b0000) begin
        we_seen = we; a_seen = daddr; d_seen = dwdata;
      end
      if (i == 1 && !w) a_seen = daddr;
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, we} !== 6'd0) begin
      errors++; $display("FAIL rst_ctl got %b%b%b exp 0", rsp_valid, rsp_err, we);
    end
    checks++;
    if ({daddr, dwdata, rsp_rdata} !== 96'd0) begin
      errors++; $display("FAIL rst_data got %h %h %h exp 0", daddr, dwdata, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_word();
    int lat; logic [3:0] ws; logic [31:0] as, ds, rd; logic e;
    run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, lat, ws, as, ds, rd, e);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_lat got %0d exp 2", lat); end
    checks++;
    if ({ws, as, ds} !== {4'b1111, 32'h08, 32'hDEADBEEF}) begin
      errors++; $display("FAIL sw_port got %b %h %h exp 1111 00000008 deadbeef", ws, as, ds);
    end
    checks++;
    if ({e, rd} !== 33'd0) begin
      errors++; $display("FAIL sw_rsp got err %b data %h exp 0 0", e, rd);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_rdata} !== 33'd0) begin
      errors++; $display("FAIL sw_pulse got %b %h exp 0 0", rsp_valid, rsp_rdata);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, ws, as, ds, rd, e);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw_lat got %0d exp 3", lat); end
    checks++;
    if ({e, rd} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw_data got err %b data %h exp 0 deadbeef", e, rd);
    end
    checks++;
    if (ws !== 4'b0000) begin errors++; $display("FAIL lw_we got %b exp 0000", ws); end
  endtask

  task automatic test_byte();
    int lat; logic [3:0] ws; logic [31:0] as, ds, rd; logic e;
    run_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h123456A5, lat, ws, as, ds, rd, e);
    checks++;
    if ({ws, as, ds} !== {4'b0010, 32'h0C, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL sb_port got %b %h %h exp 0010 0000000c a5a5a5a5", ws, as, ds);
    end
    run_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, ws, as, ds, rd, e);
    checks++;
    if ({lat, rd} !== {32'd3, 32'hFFFFFFA5}) begin
      errors++; $display("FAIL lb_signed got lat %0d data %h exp 3 ffffffa5", lat, rd);
    end
    run_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, ws, as, ds, rd, e);
    checks++;
    if ({lat, rd} !== {32'd3, 32'h000000A5}) begin
      errors++; $display("FAIL lbu got lat %0d data %h exp 3 000000a5", lat, rd);
    end
  endtask

  task automatic test_half();
    int lat; logic [3:0] ws; logic [31:0] as, ds, rd; logic e;
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, lat, ws, as, ds, rd, e);
    checks++;
    if ({ws, as, ds} !== {4'b1100, 32'h10, 32'h80018001}) begin
      errors++; $display("FAIL sh_port got %b %h %h exp 1100 00000010 80018001", ws, as, ds);
    end
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, ws, as, ds, rd, e);
    checks++;
    if ({lat, rd} !== {32'd3, 32'hFFFF8001}) begin
      errors++; $display("FAIL lh_signed got lat %0d data %h exp 3 ffff8001", lat, rd);
    end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, ws, as, ds, rd, e);
    checks++;
    if (rd !== 32'h00008001) begin
      errors++; $display("FAIL lhu got %h exp 00008001", rd);
    end
  endtask

  task automatic test_errors();
    int lat; logic [3:0] ws; logic [31:0] as, ds, rd; logic e;
    logic        ew [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  es [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] ea [4] = '{32'h03, 32'h06, 32'h80, 32'h04};
    for (int k = 0; k < 4; k++) begin
      run_req(ew[k], es[k], 1'b0, ea[k], 32'hFFFFFFFF, lat, ws, as, ds, rd, e);
      checks++;
      if ({lat, e, rd, ws} !== {32'd1, 1'b1, 32'd0, 4'b0000}) begin
        errors++;
        $display("FAIL err_%0d got lat %0d err %b data %h we %b exp 1 1 0 0000",
                 k, lat, e, rd, ws);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_rsp = 0;
    int acc_c [2] = '{-1, -1};
    int rsp_c [2] = '{-1, -1};
    logic [31:0] rsp_d [2] = '{32'd0, 32'd0};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h08;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) begin
        if (n_rsp < 2) begin rsp_c[n_rsp] = c; rsp_d[n_rsp] = rsp_rdata; end
        n_rsp++;
      end
      if (req_valid && req_ready) begin
        if (n_acc < 2) acc_c[n_acc] = c;
        n_acc++;
        if (n_acc == 2) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({n_acc, n_rsp} !== {32'd2, 32'd2}) begin
      errors++; $display("FAIL b2b_count got acc %0d rsp %0d exp 2 2", n_acc, n_rsp);
    end
    checks++;
    if ({acc_c[0], acc_c[1], rsp_c[0], rsp_c[1]} !== {32'd0, 32'd4, 32'd3, 32'd7}) begin
      errors++;
      $display("FAIL b2b_timing got acc %0d %0d rsp %0d %0d exp 0 4 3 7",
               acc_c[0], acc_c[1], rsp_c[0], rsp_c[1]);
    end
    checks++;
    if ({rsp_d[0], rsp_d[1]} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL b2b_data got %h %h exp deadbeef deadbeef", rsp_d[0], rsp_d[1]);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (we !== 4'b1111) begin errors++; $display("FAIL mid_issue_we got %b exp 1111", we); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({we, rsp_valid, req_ready} !== 6'd0) begin
      errors++; $display("FAIL mid_async got we %b vld %b rdy %b exp 0", we, rsp_valid, req_ready);
    end
    checks++;
    if (daddr !== 32'd0) begin errors++; $display("FAIL mid_daddr got %h exp 0", daddr); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d exp 0", seen); end
    checks++;
    if (mem[8] !== 32'd0) begin errors++; $display("FAIL mid_no_write got %h exp 0", mem[8]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
